// File: rtl/multiplier_if.sv
// Start/operand/result bundle for the sequential 32x32 multiplier.
interface multiplier_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        finish;
  logic [63:0] product;

  modport master (output start, multiplicand, multiplier,
                  input  busy, finish, product);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, finish, product);
endinterface

// File: rtl/multiplier.sv
// Sequential 32x32 -> 64 multiplier, one radix-2 step per clock, fixed 32-step latency.
// Define MULTIPLIER_SIGNED_EN for two's-complement Booth recoding; default is unsigned shift-add.
//
// state | meaning
// IDLE  | waiting for start, product holds last result
// CALC  | one radix-2 step per edge, 32 steps
// DONE  | product valid, finish high, start restarts
module multiplier (
  input  logic          clk,
  input  logic          rst,
  multiplier_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q;
  logic [63:0] product_q;
  logic [32:0] sum;
  logic        cur_bit;
  logic        load, step, last, busy, finish;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 6'd31) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_CALC;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    busy   = 1'b0;
    finish = 1'b0;
    case (state_q)
      S_IDLE: load = bus.start;
      S_CALC: begin
        step = 1'b1;
        busy = 1'b1;
        last = (cnt_q == 6'd31);
      end
      S_DONE: begin
        finish = 1'b1;
        load   = bus.start;
      end
      default: ;
    endcase
  end

  assign cur_bit = b_q[cnt_q[4:0]];

`ifdef MULTIPLIER_SIGNED_EN
  logic bprev_q;

  // Booth pair {B[i],B[i-1]}; 33-bit signed add keeps the carry before the arithmetic shift
  always_comb begin
    case ({cur_bit, bprev_q})
      2'b01:   sum = {acc_q[63], acc_q[63:32]} + {a_q[31], a_q};
      2'b10:   sum = {acc_q[63], acc_q[63:32]} - {a_q[31], a_q};
      default: sum = {acc_q[63], acc_q[63:32]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)      bprev_q <= 1'b0;
    else if (load) bprev_q <= 1'b0;
    else if (step) bprev_q <= cur_bit;
  end
`else
  always_comb begin
    sum = {1'b0, acc_q[63:32]} + (cur_bit ? {1'b0, a_q} : 33'd0);
  end
`endif

  // sum[32] becomes the new top bit: carry for unsigned, sign extension for Booth
  assign acc_d = {sum, acc_q[31:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 6'd0;
      product_q <= 64'd0;
    end else begin
      if (load) begin
        a_q   <= bus.multiplicand;
        b_q   <= bus.multiplier;
        acc_q <= 64'd0;
        cnt_q <= 6'd0;
      end else if (step) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 6'd1;
      end
      if (last) product_q <= acc_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.finish  = finish;
  assign bus.product = product_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: stimulus pushes model products, a monitor checks each finish.
module tb_multiplier;

  typedef struct {
    logic [63:0] exp;
    int          acc_cyc;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic fin_prev = 1'b0;
  logic [63:0] last_exp = 64'd0;
  entry_t sb_q[$];

  multiplier_if mif ();

  multiplier dut (.clk(clk), .rst(rst), .bus(mif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTIPLIER_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (mif.busy && mif.finish) begin
      miscompares++;
      $display("FAIL busy_finish_overlap: busy=1 finish=1 at cycle %0d, expected never both", cyc);
    end
    if (rst && mif.finish && !fin_prev) begin
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_finish: finish at cycle %0d, expected no pending op", cyc);
      end else begin
        e = sb_q.pop_front();
        check64("product", mif.product, e.exp);
        check64("latency", 64'(cyc - e.acc_cyc), 64'd32);
        last_exp = e.exp;
      end
      done_cnt++;
    end
    fin_prev = mif.finish;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    sb_q.delete();
    check64("rst_busy", 64'(mif.busy), 64'd0);
    check64("rst_finish", 64'(mif.finish), 64'd0);
    check64("rst_product", mif.product, 64'd0);
    last_exp = 64'd0;
    rst = 1'b1;
  endtask

  // accept edge: push expected, confirm busy, scramble operands afterwards
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic keep_start);
    @(negedge clk);
    mif.start = 1'b1;
    mif.multiplicand = a;
    mif.multiplier = b;
    @(posedge clk);
    @(negedge clk);
    #1;
    sb_q.push_back('{exp: model(a, b), acc_cyc: cyc});
    check64("accept_busy", 64'({mif.busy, mif.finish}), 64'b10);
    mif.start = keep_start;
    mif.multiplicand = $urandom;
    mif.multiplier = $urandom;
  endtask

  task automatic wait_done(input int n0, input logic glitch);
    int i;
    for (i = 0; i < 40 && done_cnt == n0; i++) begin
      @(negedge clk);
      #1;
      mif.start = 1'b0;
      if (glitch && i == 9) begin
        check64("hold_product", mif.product, last_exp);
        mif.start = 1'b1;
        mif.multiplicand = 32'd0;
        mif.multiplier = 32'd0;
      end
    end
    if (done_cnt == n0) begin
      miscompares++;
      $display("FAIL timeout: no finish within 40 cycles, expected finish at 32");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic glitch);
    int n0;
    n0 = done_cnt;
    accept(a, b, 1'b0);
    wait_done(n0, glitch);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ha[3];
    logic [31:0] hb[3];
    int n0;
    mif.start = 1'b0;
    mif.multiplicand = 32'd0;
    mif.multiplier = 32'd0;
    repeat (2) @(posedge clk);
    do_reset();

    run_op(32'd3, 32'd5, 1'b0);
    check64("req25_const", mif.product, 64'h000000000000000F);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(32'hFFFFFFFE, 32'd3, 1'b0);
    run_op(32'd7, 32'd6, 1'b1);
    check64("req28_const", mif.product, 64'd42);

    n0 = done_cnt;
    accept(32'd9, 32'd9, 1'b0);
    repeat (15) @(negedge clk);
    do_reset();
    if (done_cnt != n0) begin
      miscompares++;
      $display("FAIL aborted_op: got %0d finishes, expected 0", done_cnt - n0);
    end
    run_op(32'd2, 32'd4, 1'b0);
    check64("req29_const", mif.product, 64'd8);

    ha[0] = 32'd11;         hb[0] = 32'd13;
    ha[1] = 32'h80000000;   hb[1] = 32'h7FFFFFFF;
    ha[2] = 32'h12345678;   hb[2] = 32'hFEDCBA98;
    n0 = done_cnt;
    accept(ha[0], hb[0], 1'b1);
    for (int k = 1; k < 3; k++) begin
      mif.multiplicand = ha[k];
      mif.multiplier = hb[k];
      repeat (33) @(posedge clk);
      @(negedge clk);
      #1;
      sb_q.push_back('{exp: model(ha[k], hb[k]), acc_cyc: cyc});
    end
    mif.start = 1'b0;
    wait_done(n0 + 2, 1'b0);
    check64("hold_start_count", 64'(done_cnt - n0), 64'd3);

    for (int t = 0; t < 20; t++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = 32'd0;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d pending ops, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL use one clock, clk, and one synchronous, active-low reset, rst, sampled on the rising edge of clk.
REQ-002 Port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Port rst  input  1  synchronous active-low reset; 0 at a rising edge resets the block.
REQ-004 Port start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 Port multiplicand  input  32  operand A; captured on the start-accepting edge.
REQ-006 Port multiplier  input  32  operand B; captured on the start-accepting edge.
REQ-007 Port busy  output  1  high while in CALC.
REQ-008 Port finish  output  1  high in DONE; product valid.
REQ-009 Port product  output  64  full A*B result; registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 IDLE/DONE with start=1 at an edge -> CALC: latch both operands, clear the 64-bit accumulator, set the 6-bit step counter to 0, clear finish, set busy.
REQ-012 IDLE with start=0 -> stay in IDLE. DONE with start=0 -> stay in DONE, holding product and finish.
REQ-013 In CALC, each edge SHALL perform one radix-2 step (examine one multiplier bit, conditionally add the shifted multiplicand to the accumulator, shift) and increment the counter.
REQ-014 After the 32nd CALC step, the block SHALL go to DONE on that same edge: product <= accumulator, finish <= 1, busy <= 0.
REQ-015 Latency: finish SHALL first read high 32 clock cycles after the edge that accepted start, independent of operand values (no early termination).
REQ-016 start during CALC SHALL be ignored; operands, counter and result are unaffected.
REQ-017 Operand input changes after the start-accepting edge SHALL NOT affect the result.
REQ-018 product SHALL change only on the CALC->DONE edge or on reset; it holds through IDLE, a new CALC, and DONE.
REQ-019 Arithmetic SHALL be exact modulo 2^64 for the selected mode (see Configuration); the internal partial sum SHALL be at least 33 bits wide so carries are not lost.
REQ-020 busy and finish SHALL never be high together.

Reset
REQ-021 rst=0 at an edge SHALL force state=IDLE, busy=0, finish=0, product=64'h0, and clear counter, accumulator and operand registers; this takes priority over start.
REQ-022 Reset during CALC SHALL abort the operation with no partial result visible; the next accepted start SHALL compute correctly.

Configuration
REQ-023 Macro MULTIPLIER_SIGNED_EN defined: operands SHALL be treated as two's complement and multiplied with radix-2 Booth recoding (bit pair {B[i],B[i-1]}, B[-1]=0), with an arithmetic right shift of the accumulator; product is the 64-bit signed product.
REQ-024 Macro MULTIPLIER_SIGNED_EN undefined: operands SHALL be treated as unsigned and multiplied with shift-add; product is the 64-bit unsigned product. The port list and latency are identical in both builds.

Verification
REQ-025 Both builds: A=3, B=5, start pulse -> 32 cycles later finish=1, busy=0, product=64'h000000000000000F.
REQ-026 Unsigned build: A=B=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; signed build -> product=64'h0000000000000001.
REQ-027 A=32'hFFFFFFFE, B=3 -> unsigned product=64'h00000002FFFFFFFA; signed product=64'hFFFFFFFFFFFFFFFA.
REQ-028 Start A=7, B=6; at step 10 pulse start with A=B=0 and change the operands -> ignored; finish still comes at cycle 32 with product=64'd42.
REQ-029 Start A=9, B=9; drive rst=0 at step 15 -> next cycle busy=0, finish=0, product=0; then start A=2, B=4 -> product=64'd8 after 32 cycles.
REQ-030 Hold start=1 continuously in DONE -> a new operation starts every 33 cycles with a one-cycle finish between them; product is updated each time.
